// File: rtl/gan_stream_pkg.sv
// Shared constants and types for the layer output streaming path.
// The LAYER_STREAM_PIXEL_EN build option uses Q88_ONE for pixel conversion.
package gan_stream_pkg;

    localparam logic signed [15:0] Q88_ONE   = 16'sh0100;
    localparam int                 FRAC_BITS = 8;

    localparam int GS_N = 256;
    localparam int GS_W = 16;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/q88_to_pixel.sv
// Combinational signed Q8.8 to 8-bit pixel mapping: clamp((q + 1.0) / 2 * 256, 0, 255).
// Instantiated by layer_output_streamer only when LAYER_STREAM_PIXEL_EN is defined.
module q88_to_pixel
    import gan_stream_pkg::*;
#(
    parameter int W = GS_W
) (
    input  logic [W-1:0] q,
    output logic [7:0]   pix
);

    localparam logic signed [W:0] BIAS    = (W+1)'(Q88_ONE);
    localparam logic signed [W:0] PIX_MAX = (W+1)'(255);

    logic signed [W:0] sum;
    logic signed [W:0] half;

    // One extra bit of headroom so +1.0 bias cannot wrap the most positive word.
    assign sum  = $signed({q[W-1], q}) + BIAS;
    assign half = sum >>> 1;

    always_comb begin
        pix = '0;
        if (half[W])
            pix = '0;
        else if (half > PIX_MAX)
            pix = '1;
        else
            pix = half[7:0];
    end

endmodule

// File: rtl/layer_output_streamer.sv
// Snapshots a layer's flattened output bus on the rising edge of done and streams it
// word by word over valid/ready. Define LAYER_STREAM_PIXEL_EN for pixel output.
module layer_output_streamer
    import gan_stream_pkg::*;
#(
    parameter int N     = GS_N,
    parameter int W     = GS_W,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_in,
    input  logic [W*N-1:0]   flat_output_flat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             m_last,
    output logic             busy,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    stream_state_t    state;
    logic             done_q;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     buf_mem [N];

    logic done_rise;
    logic xfer;
    logic final_xfer;
    logic capture;
    logic drop;

    assign done_rise  = done_in & ~done_q;
    assign xfer       = (state == S_STREAM) & m_ready;
    assign final_xfer = xfer & (idx == LAST_IDX);
    // A done edge coinciding with the final transfer is a legal back-to-back capture.
    assign capture    = done_rise & ((state == S_IDLE) | final_xfer);
    assign drop       = done_rise & (state == S_STREAM) & ~final_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            state   <= S_IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            done_q <= done_in;
            if (capture) begin
                state <= S_STREAM;
                idx   <= '0;
            end else if (xfer) begin
                if (idx == LAST_IDX) begin
                    state <= S_IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (drop)
                overrun <= 1'b1;
        end
    end

    // Parallel write of every word on capture, so this stays a register array.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < N; i++)
                buf_mem[i] <= flat_output_flat[i*W +: W];
        end
    end

    logic [W-1:0] word;
    assign word = buf_mem[idx];

    logic [W-1:0] word_out;

`ifdef LAYER_STREAM_PIXEL_EN
    logic [7:0] pix;

    q88_to_pixel #(.W(W)) u_pix (
        .q   (word),
        .pix (pix)
    );

    assign word_out = {{(W-8){1'b0}}, pix};
`else
    assign word_out = word;
`endif

    assign busy    = (state == S_STREAM);
    assign m_valid = busy;
    assign m_index = idx;
    assign m_last  = busy & (idx == LAST_IDX);
    assign m_data  = busy ? word_out : '0;

endmodule

// File: tb/tb_layer_output_streamer.sv
// Scoreboard bench for layer_output_streamer; pixel expectations apply when
// LAYER_STREAM_PIXEL_EN is defined.
module tb_layer_output_streamer;

    localparam int N     = 256;
    localparam int W     = 16;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             done_in;
    logic [W*N-1:0]   flat;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic [IDX_W-1:0] m_index;
    logic             m_last;
    logic             busy;
    logic             overrun;

    typedef struct {
        logic [W-1:0]     data;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          rand_mode = 1'b0;

    layer_output_streamer #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .done_in          (done_in),
        .flat_output_flat (flat),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_index          (m_index),
        .m_last           (m_last),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] q);
`ifdef LAYER_STREAM_PIXEL_EN
        int v;
        v = (int'($signed(q)) + 256) >>> 1;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return W'(v);
`else
        return q;
`endif
    endfunction

    // Consumer side: pop on every accepted word, verify stall stability.
    bit               prev_stall = 1'b0;
    logic [W-1:0]     prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic             prev_last;
    exp_t             e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data",  32'(m_data),  32'(prev_data));
                chk("stall_index", 32'(m_index), 32'(prev_idx));
                chk("stall_last",  32'(m_last),  32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(m_index), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("data",  32'(m_data),  32'(e.data));
                    chk("index", 32'(m_index), 32'(e.idx));
                    chk("last",  32'(m_last),  32'(e.idx == IDX_W'(N - 1)));
                end
            end else if (!m_valid) begin
                chk("last_idle", 32'(m_last), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic push_vec(input logic [W*N-1:0] v);
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.data = model(v[i*W +: W]);
            x.idx  = IDX_W'(i);
            sb.push_back(x);
        end
    endtask

    task automatic drive_done(input logic [W*N-1:0] v);
        flat    = v;
        done_in = 1'b1;
        @(posedge clk);
        #1;
        done_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 4000 && sb.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_valid_low"}, 32'(m_valid), 32'd0);
        chk({tag, "_busy_low"},  32'(busy),    32'd0);
    endtask

    task automatic wait_idx(input int target);
        bit found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_index == IDX_W'(target)) found = 1'b1;
        end
        chk("reach_index", 32'(found), 32'd1);
    endtask

    logic [W*N-1:0] va, vb;

    initial begin
        rst     = 1'b1;
        done_in = 1'b0;
        flat    = '0;
        #12;
        chk("rst_valid",   32'(m_valid), 32'd0);
        chk("rst_last",    32'(m_last),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_index",   32'(m_index), 32'd0);
        chk("rst_data",    32'(m_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero vector, ready held high.
        @(posedge clk);
        #1;
        va = '0;
        push_vec(va);
        drive_done(va);
        chk("latency_valid", 32'(m_valid), 32'd1);
        chk("latency_index", 32'(m_index), 32'd0);
        wait_drain("zero_drain");

        // Ramp vector with random backpressure.
        for (int i = 0; i < N; i++) va[i*W +: W] = W'(i * 16'h0101);
        rand_mode = 1'b1;
        @(posedge clk);
        #1;
        push_vec(va);
        drive_done(va);
        wait_drain("ramp_drain");
        rand_mode = 1'b0;
        chk("ramp_overrun", 32'(overrun), 32'd0);

        // Done edge mid-stream is dropped and flags overrun.
        for (int i = 0; i < N; i++) va[i*W +: W] = W'(i * 3 + 16'h8007);
        @(posedge clk);
        #1;
        push_vec(va);
        drive_done(va);
        wait_idx(100);
        @(posedge clk);
        #1;
        drive_done(~va);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_drain("overrun_drain");
        chk("overrun_sticky", 32'(overrun), 32'd1);
        for (int i = 0; i < N; i++) vb[i*W +: W] = W'(16'hFFFF - i * 5);
        @(posedge clk);
        #1;
        push_vec(vb);
        drive_done(vb);
        wait_drain("third_drain");
        chk("overrun_persist", 32'(overrun), 32'd1);

        #2;
        rst = 1'b1;
        #1;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back: done rises on the final transfer edge.
        for (int i = 0; i < N; i++) va[i*W +: W] = W'(i * 16'h0011 + 16'h0F00);
        for (int i = 0; i < N; i++) vb[i*W +: W] = W'(16'h7000 ^ (i * 16'h0203));
        @(posedge clk);
        #1;
        push_vec(va);
        drive_done(va);
        wait_idx(254);
        @(posedge clk);
        #1;
        push_vec(vb);
        drive_done(vb);
        chk("b2b_valid",   32'(m_valid), 32'd1);
        chk("b2b_index",   32'(m_index), 32'd0);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        wait_drain("b2b_drain");
        chk("b2b_overrun_end", 32'(overrun), 32'd0);

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        push_vec(va);
        drive_done(va);
        wait_idx(50);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_busy",  32'(busy),    32'd0);
        chk("arst_index", 32'(m_index), 32'd0);
        chk("arst_data",  32'(m_data),  32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_vec(vb);
        drive_done(vb);
        chk("post_rst_index", 32'(m_index), 32'd0);
        wait_drain("post_rst_drain");

`ifdef LAYER_STREAM_PIXEL_EN
        begin
            logic [15:0] pin  [6] = '{16'hFF00, 16'h0000, 16'h0100, 16'h7FFF, 16'h8000, 16'h0080};
            logic [15:0] pout [6] = '{16'd0, 16'd128, 16'd255, 16'd255, 16'd0, 16'd192};
            exp_t x;
            va = '0;
            for (int i = 0; i < 6; i++) va[i*W +: W] = pin[i];
            for (int i = 0; i < N; i++) begin
                x.data = (i < 6) ? pout[i] : 16'd128;
                x.idx  = IDX_W'(i);
                sb.push_back(x);
            end
            @(posedge clk);
            #1;
            drive_done(va);
            wait_drain("pixel_drain");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
